// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// RV32I funct3 codes, the spanning test and load sign/zero extension.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        WR0,
        WR1,
        RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when the access touches bytes of the following word as well.
    function automatic logic isSpanning(input logic [2:0] funct3, input logic [1:0] offset);
        logic is_half;
        logic is_word;
        is_half = (funct3 == F3_H) || (funct3 == F3_HU);
        is_word = (funct3 == F3_W);
        return (is_half && (offset == 2'd3)) || (is_word && (offset != 2'd0));
    endfunction

    function automatic logic [31:0] extendLoad(input logic [2:0] funct3, input logic [31:0] bytes);
        logic [31:0] res;
        case (funct3)
            F3_B:    res = {{24{bytes[7]}}, bytes[7:0]};
            F3_H:    res = {{16{bytes[15]}}, bytes[15:0]};
            F3_BU:   res = {24'd0, bytes[7:0]};
            F3_HU:   res = {16'd0, bytes[15:0]};
            default: res = bytes;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle of the load/store unit.
interface load_store_unit_if #(
    parameter int dataW = 32,
    parameter int addrW = 32
) ();

    logic             reqValid;
    logic             reqReady;
    logic             reqWrite;
    logic [2:0]       reqFunct3;
    logic [addrW-1:0] reqAddr;
    logic [dataW-1:0] reqData;
    logic             respValid;
    logic             respErr;
    logic [dataW-1:0] respData;

    modport master (
        output reqValid, reqWrite, reqFunct3, reqAddr, reqData,
        input  reqReady, respValid, respErr, respData
    );

    modport slave (
        input  reqValid, reqWrite, reqFunct3, reqAddr, reqData,
        output reqReady, respValid, respErr, respData
    );

endinterface

// File: rtl/lsu_byte_lane.sv
// Byte steering for the load/store unit: extracts and extends load bytes from
// the word pair {w1,w0}, and merges store bytes into that pair.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic        sel_hi,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [63:0] pair;
    logic [63:0] shifted;
    logic [63:0] ins_data;
    logic [63:0] merged;
    logic [3:0]  size_mask;
    logic [7:0]  byte_mask;

    always_comb begin
        pair    = {w1, w0};
        shifted = pair >> {offset, 3'b000};
        load_data = extendLoad(funct3, shifted[31:0]);

        case (funct3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        byte_mask = {4'b0000, size_mask} << offset;
        ins_data  = {32'd0, store_data} << {offset, 3'b000};

        // Unaddressed bytes keep the value read from RAM.
        merged = pair;
        for (int k = 0; k < 8; k++) begin
            if (byte_mask[k]) begin
                merged[8*k +: 8] = ins_data[8*k +: 8];
            end
        end
        merged_word = sel_hi ? merged[63:32] : merged[31:0];
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-only RAM: sub-word stores via
// read-modify-write. LSU_MISALIGNED_SPLIT_EN enables split spanning accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int dataW = 32,
    parameter int addrW = 32
) (
    input  logic              clock,
    input  logic              reset,
    load_store_unit_if.slave  core,
    output logic [addrW-1:0]  RAMAddr,
    output logic [dataW-1:0]  RAMDataIn,
    output logic              WriteControl,
    input  logic [dataW-1:0]  RAMDataOut
);

    lsu_state_t       state_q, state_d;
    logic             write_q, write_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [addrW-1:0] addr_q, addr_d;
    logic [dataW-1:0] data_q, data_d;
    logic [dataW-1:0] w0_q, w0_d;
    logic             err_q, err_d;
    logic [dataW-1:0] resp_data_q, resp_data_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [dataW-1:0] w1_q, w1_d;
    logic [addrW-1:0] word1;
`endif

    logic [addrW-1:0] word0;
    logic [2:0]       req_f3;
    logic [1:0]       req_off;
    logic             req_illegal;
    logic             spanning;
    logic             wr_en;
    logic [dataW-1:0] lane_w0;
    logic [dataW-1:0] lane_w1;
    logic             lane_sel_hi;
    logic [dataW-1:0] lane_load;
    logic [dataW-1:0] lane_merged;

    assign word0 = {addr_q[addrW-1:2], 2'b00};
`ifdef LSU_MISALIGNED_SPLIT_EN
    assign word1       = word0 + addrW'(4);
    assign spanning    = isSpanning(funct3_q, addr_q[1:0]);
    assign lane_w1     = (state_q == RD1) ? RAMDataOut : w1_q;
    assign lane_sel_hi = (state_q == WR1);
`else
    assign spanning    = 1'b0;
    assign lane_w1     = '0;
    assign lane_sel_hi = 1'b0;
`endif
    // While a read is in flight the lane sees the live RAM word directly.
    assign lane_w0 = (state_q == RD0) ? RAMDataOut : w0_q;

    lsu_byte_lane u_byte_lane (
        .funct3      (funct3_q),
        .offset      (addr_q[1:0]),
        .store_data  (data_q),
        .w0          (lane_w0),
        .w1          (lane_w1),
        .sel_hi      (lane_sel_hi),
        .load_data   (lane_load),
        .merged_word (lane_merged)
    );

    always_comb begin
        req_f3  = core.reqFunct3;
        req_off = core.reqAddr[1:0];
        req_illegal = (req_f3 == 3'b011) || (req_f3[2:1] == 2'b11) ||
                      (core.reqWrite && req_f3[2]);
`ifndef LSU_MISALIGNED_SPLIT_EN
        req_illegal = req_illegal ||
                      ((req_f3[1:0] == 2'b01) && req_off[0]) ||
                      ((req_f3 == F3_W) && (req_off != 2'd0));
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= '0;
            data_q      <= '0;
            w0_q        <= '0;
            err_q       <= 1'b0;
            resp_data_q <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            w1_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            w0_q        <= w0_d;
            err_q       <= err_d;
            resp_data_q <= resp_data_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
            w1_q        <= w1_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        data_d      = data_q;
        w0_d        = w0_q;
        err_d       = err_q;
        resp_data_d = resp_data_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
        w1_d        = w1_q;
`endif
        case (state_q)
            IDLE: begin
                if (core.reqValid) begin
                    write_d  = core.reqWrite;
                    funct3_d = req_f3;
                    addr_d   = core.reqAddr;
                    data_d   = core.reqData;
                    if (req_illegal) begin
                        state_d     = RESP;
                        err_d       = 1'b1;
                        resp_data_d = '0;
                    end else if (core.reqWrite && (req_f3 == F3_W) && (req_off == 2'd0)) begin
                        state_d = WR0;
                    end else begin
                        state_d = RD0;
                    end
                end
            end
            RD0: begin
                w0_d = RAMDataOut;
                if (spanning) begin
                    state_d = RD1;
                end else if (write_q) begin
                    state_d = WR0;
                end else begin
                    state_d     = RESP;
                    err_d       = 1'b0;
                    resp_data_d = lane_load;
                end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            RD1: begin
                w1_d = RAMDataOut;
                if (write_q) begin
                    state_d = WR0;
                end else begin
                    state_d     = RESP;
                    err_d       = 1'b0;
                    resp_data_d = lane_load;
                end
            end
            WR1: begin
                state_d     = RESP;
                err_d       = 1'b0;
                resp_data_d = '0;
            end
`endif
            WR0: begin
                if (spanning) begin
                    state_d = WR1;
                end else begin
                    state_d     = RESP;
                    err_d       = 1'b0;
                    resp_data_d = '0;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core.reqReady  = (state_q == IDLE);
        core.respValid = (state_q == RESP);
        core.respErr   = err_q;
        core.respData  = resp_data_q;
        RAMAddr   = '0;
        RAMDataIn = '0;
        wr_en     = 1'b0;
        case (state_q)
            RD0: RAMAddr = word0;
            WR0: begin
                RAMAddr   = word0;
                RAMDataIn = lane_merged;
                wr_en     = 1'b1;
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            RD1: RAMAddr = word1;
            WR1: begin
                RAMAddr   = word1;
                RAMDataIn = lane_merged;
                wr_en     = 1'b1;
            end
`endif
            default: ;
        endcase
        // A reset landing in the middle of a read-modify-write must not write.
        WriteControl = wr_en && reset;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the RV32I core's memory stage and the zero-delay word RAM.
- Turns LB/LH/LW/LBU/LHU/SB/SH/SW requests into whole-word RAM reads and writes; the RAM itself only reads and writes aligned 32-bit words.
- Sub-word stores use read-modify-write. Loads are byte-extracted and sign- or zero-extended.
- Uses a valid/ready request and a single-cycle response pulse toward the core.

Parameters:
- dataW, 32, data width; fixed at 32, other values unsupported.
- addrW, 32, byte address width; must match the RAM's RAMAddrSize.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- reqValid  in  1  core request present.
- reqReady  out  1  high only in IDLE; a request is accepted on a rising edge with reqValid&&reqReady.
- reqWrite  in  1  1=store, 0=load.
- reqFunct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- reqAddr  in  addrW  byte address.
- reqData  in  dataW  store data; low bytes used for B/H.
- respValid  out  1  one-cycle completion pulse.
- respErr  out  1  qualified by respValid: illegal funct3 or unsupported misalignment.
- respData  out  dataW  extended load result; 0 for stores and errors; held until next respValid.
- RAMAddr  out  addrW  word-aligned byte address to RAM (low 2 bits always 0).
- RAMDataIn  out  dataW  write word to RAM.
- WriteControl  out  1  RAM write strobe.
- RAMDataOut  in  dataW  combinational RAM read word.

Behaviour:
- Little-endian: byte k of a word = bits [8k+7:8k]. offset = reqAddr[1:0].
- Reset (reset==0 at an edge) puts the FSM in IDLE and clears all registers.
  - Output values after reset: reqReady=1, respValid=0, respErr=0, respData=0, RAMAddr=0, RAMDataIn=0, WriteControl=0.
  - WriteControl is combinationally forced 0 while reset==0, so a reset arriving mid-RMW never writes.
- FSM states: IDLE, RD0, RD1, WR0, WR1, RESP. On accept, latch op, address, data and offset.
- IDLE transitions:
  - Illegal funct3 (011/110/111), or reqWrite with funct3 1xx: go to RESP with the error flag set; no RAM access.
  - Aligned SW: go to WR0 (no read).
  - Otherwise: go to RD0.
- RD0: RAMAddr=word0 address. Capture RAMDataOut into w0. Next state:
  - spanning access: RD1;
  - store: WR0;
  - load: RESP.
- RD1: RAMAddr=word0 address+4, wrapping modulo 2^addrW. Capture w1. Next state: WR0 for a store, RESP for a load.
- WR0: RAMAddr=word0 address, RAMDataIn=merged w0, WriteControl=1. Next state: WR1 if spanning, else RESP.
- WR1: address+4 (wrapping), RAMDataIn=merged w1, WriteControl=1. Next state: RESP.
- RESP: respValid=1; respErr and respData are registered values. Next state: IDLE.
- Spanning access: H at offset 3, or W at offset≠0.
  - H at offset 1 stays within one word; it is legal and not spanning.
- Latency (cycles from the accepting edge to the respValid cycle):
  - aligned or non-spanning load: 2;
  - aligned SW: 2;
  - sub-word store: 3;
  - spanning load: 3;
  - spanning store: 5;
  - error: 1.
- Merge: only the addressed bytes are replaced; all other bytes come from the read data.
- Extract: B/H sign-extend bit 7/15; BU/HU zero-extend.
- reqValid while busy is ignored, because reqReady=0 outside IDLE.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined: spanning accesses are split into two word accesses as above.
- Undefined:
  - Illegal alignments are H with offset[0]=1 and W with offset≠0.
  - These go directly to RESP with respErr=1 and respData=0; no RAM access.
  - RD1 and WR1 are not built.

Decomposition:
- lsu_pkg contains:
  - lsu_state_t enum;
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - function isSpanning(funct3, offset);
  - function extendLoad(funct3, bytes).
- One sub-module: lsu_byte_lane.
  - Combinational merge of store bytes into w0/w1.
  - Extraction of load bytes from w0/w1 for a given offset and size.

Test Plan:
- LW: RAM word 0x40 = 0x8899AABB; load LW 0x40 -> respData 0x8899AABB, respValid 2 cycles after accept, no WriteControl.
- LB/LBU: RAM word 0x40 = 0x8899AABB; LB 0x43 -> 0xFFFFFF88; LBU 0x43 -> 0x00000088; LH 0x42 -> 0xFFFF8899.
- SB: word 0x50 = 0x11223344; SB 0x51 with data 0xAB -> exactly one write of 0x1122AB44 to 0x50; respValid 3 cycles after accept; respErr=0.
- Spanning SW (with LSU_MISALIGNED_SPLIT_EN):
  - Setup: words 0x60 = 0x00000000, 0x64 = 0x00000000.
  - Stimulus: SW 0x62 with data 0xDEADBEEF.
  - Expected: 0x60 = 0xBEEF0000, 0x64 = 0x0000DEAD, in two WriteControl cycles.
  - Variant: LH 0xFFFFFFFF reads bytes from the top word and from word 0 (address wrap).
- Misaligned LW without the macro: LW 0x62 -> respErr=1, respData=0, no RAM write. Illegal funct3 011 -> respErr=1 one cycle after accept.
- Reset during RMW: reset=0 during WR0 of an SB -> WriteControl=0 that cycle, target word unchanged, FSM in IDLE, reqReady=1 next cycle.
